// File: rtl/pe_seq_ctrl_if.sv
// Control bundle between the PE-array sequencer and its environment:
// job configuration/handshake in, buffer strobes and status out.
interface pe_seq_ctrl_if #(
  parameter int A_ADDR_WIDTH = 2,
  parameter int B_ADDR_WIDTH = 2,
  parameter int O_ADDR_WIDTH = 2
) ();

  logic                    start;
  logic                    hold;
  logic [B_ADDR_WIDTH-1:0] num_k;
  logic [O_ADDR_WIDTH-1:0] num_tiles;
  logic                    enA;
  logic [A_ADDR_WIDTH-1:0] addrA;
  logic                    enB;
  logic [B_ADDR_WIDTH-1:0] addrB;
  logic                    rst_acc;
  logic                    acc_en;
  logic                    enO;
  logic                    wrO;
  logic [O_ADDR_WIDTH-1:0] addrO;
  logic                    busy;
  logic                    done;

  modport master (
    input  start, hold, num_k, num_tiles,
    output enA, addrA, enB, addrB, rst_acc, acc_en, enO, wrO, addrO, busy, done
  );

  modport slave (
    output start, hold, num_k, num_tiles,
    input  enA, addrA, enB, addrB, rst_acc, acc_en, enO, wrO, addrO, busy, done
  );

endinterface

// File: rtl/pe_seq_ctrl.sv
// Sequencer for a PE array: per output tile it clears the accumulators, streams
// num_k A/B buffer reads, waits out the PE pipeline and writes the tile result.
module pe_seq_ctrl #(
  parameter int A_ADDR_WIDTH = 2,
  parameter int B_ADDR_WIDTH = 2,
  parameter int O_ADDR_WIDTH = 2,
  parameter int PIPE_LAT     = 2
) (
  input logic              clk,
  input logic              rst,
  pe_seq_ctrl_if.master    bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(PIPE_LAT - 1);

  state_t                  state_r, stateNext_s;
  logic [B_ADDR_WIDTH-1:0] numK_r, numKNext_s;
  logic [O_ADDR_WIDTH-1:0] numTiles_r, numTilesNext_s;
  logic [B_ADDR_WIDTH-1:0] kCnt_r, kNext_s;
  logic [A_ADDR_WIDTH-1:0] aPtr_r, aPtrNext_s;
  logic [O_ADDR_WIDTH-1:0] tile_r, tileNext_s;
  logic [3:0]              drainCnt_r, drainNext_s;
  logic                    lastRead_r, lastNext_s;
  logic                    issue_s;

  logic                    enRd_r, enRdNext_s;
  logic [A_ADDR_WIDTH-1:0] addrA_r, addrANext_s;
  logic [B_ADDR_WIDTH-1:0] addrB_r, addrBNext_s;
  logic                    rstAcc_r, rstAccNext_s;
  logic                    accEn_r;
  logic                    wrO_r, wrONext_s;
  logic [O_ADDR_WIDTH-1:0] addrO_r, addrONext_s;
  logic                    busy_r, busyNext_s;
  logic                    done_r, doneNext_s;

  // Next-state, counter and registered-output decode
  always_comb begin
    stateNext_s    = state_r;
    numKNext_s     = numK_r;
    numTilesNext_s = numTiles_r;
    kNext_s        = kCnt_r;
    aPtrNext_s     = aPtr_r;
    tileNext_s     = tile_r;
    drainNext_s    = drainCnt_r;
    lastNext_s     = lastRead_r;
    issue_s        = 1'b0;
    enRdNext_s     = 1'b0;
    addrANext_s    = {A_ADDR_WIDTH{1'b0}};
    addrBNext_s    = {B_ADDR_WIDTH{1'b0}};
    addrONext_s    = {O_ADDR_WIDTH{1'b0}};

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          numKNext_s     = bus.num_k;
          numTilesNext_s = bus.num_tiles;
          aPtrNext_s     = {A_ADDR_WIDTH{1'b0}};
          tileNext_s     = {O_ADDR_WIDTH{1'b0}};
          kNext_s        = {B_ADDR_WIDTH{1'b0}};
          lastNext_s     = 1'b0;
          if ((bus.num_k != {B_ADDR_WIDTH{1'b0}}) && (bus.num_tiles != {O_ADDR_WIDTH{1'b0}})) begin
            stateNext_s = CLEAR;
          end else begin
            stateNext_s = DONE;
          end
        end else begin
          stateNext_s = IDLE;
        end
      end
      // The read shown during a FEED cycle is decided at the edge that opens it.
      CLEAR: begin
        stateNext_s = FEED;
        issue_s     = ~bus.hold;
      end
      FEED: begin
        if (lastRead_r) begin
          stateNext_s = DRAIN;
          drainNext_s = DRAIN_LOAD;
          lastNext_s  = 1'b0;
        end else begin
          issue_s = ~bus.hold;
        end
      end
      DRAIN: begin
        if (drainCnt_r == 4'd0) begin
          stateNext_s = WRITE;
        end else begin
          drainNext_s = drainCnt_r - 4'd1;
        end
      end
      WRITE: begin
        if (tile_r == (numTiles_r - O_ADDR_WIDTH'(1))) begin
          stateNext_s = DONE;
        end else begin
          tileNext_s  = tile_r + O_ADDR_WIDTH'(1);
          kNext_s     = {B_ADDR_WIDTH{1'b0}};
          lastNext_s  = 1'b0;
          stateNext_s = CLEAR;
        end
      end
      DONE: begin
        stateNext_s = IDLE;
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase

    if (issue_s) begin
      enRdNext_s  = 1'b1;
      addrANext_s = aPtr_r;
      addrBNext_s = kCnt_r;
      aPtrNext_s  = aPtr_r + A_ADDR_WIDTH'(1);
      kNext_s     = kCnt_r + B_ADDR_WIDTH'(1);
      lastNext_s  = (kCnt_r == (numK_r - B_ADDR_WIDTH'(1)));
    end else begin
      enRdNext_s  = 1'b0;
    end

    rstAccNext_s = (stateNext_s == CLEAR);
    wrONext_s    = (stateNext_s == WRITE);
    doneNext_s   = (stateNext_s == DONE);
    busyNext_s   = (stateNext_s inside {CLEAR, FEED, DRAIN, WRITE});
    if (stateNext_s == WRITE) begin
      addrONext_s = tile_r;
    end else begin
      addrONext_s = {O_ADDR_WIDTH{1'b0}};
    end
  end

  // State, counters and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      numK_r     <= {B_ADDR_WIDTH{1'b0}};
      numTiles_r <= {O_ADDR_WIDTH{1'b0}};
      kCnt_r     <= {B_ADDR_WIDTH{1'b0}};
      aPtr_r     <= {A_ADDR_WIDTH{1'b0}};
      tile_r     <= {O_ADDR_WIDTH{1'b0}};
      drainCnt_r <= 4'd0;
      lastRead_r <= 1'b0;
      enRd_r     <= 1'b0;
      addrA_r    <= {A_ADDR_WIDTH{1'b0}};
      addrB_r    <= {B_ADDR_WIDTH{1'b0}};
      rstAcc_r   <= 1'b0;
      accEn_r    <= 1'b0;
      wrO_r      <= 1'b0;
      addrO_r    <= {O_ADDR_WIDTH{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= stateNext_s;
      numK_r     <= numKNext_s;
      numTiles_r <= numTilesNext_s;
      kCnt_r     <= kNext_s;
      aPtr_r     <= aPtrNext_s;
      tile_r     <= tileNext_s;
      drainCnt_r <= drainNext_s;
      lastRead_r <= lastNext_s;
      enRd_r     <= enRdNext_s;
      addrA_r    <= addrANext_s;
      addrB_r    <= addrBNext_s;
      rstAcc_r   <= rstAccNext_s;
      accEn_r    <= enRd_r;
      wrO_r      <= wrONext_s;
      addrO_r    <= addrONext_s;
      busy_r     <= busyNext_s;
      done_r     <= doneNext_s;
    end
  end

  assign bus.enA     = enRd_r;
  assign bus.addrA   = addrA_r;
  assign bus.enB     = enRd_r;
  assign bus.addrB   = addrB_r;
  assign bus.rst_acc = rstAcc_r;
  assign bus.acc_en  = accEn_r;
  assign bus.enO     = wrO_r;
  assign bus.wrO     = wrO_r;
  assign bus.addrO   = addrO_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Self-checking bench for pe_seq_ctrl: a cycle-schedule model built from the
// job rules is compared against the sampled outputs of every cycle of each job.
module tb_pe_seq_ctrl;

  localparam int AW   = 3;
  localparam int BW   = 3;
  localparam int OW   = 2;
  localparam int PL   = 2;
  localparam int NMAX = 200;

  logic clk = 1'b0;
  logic rst;

  // 10-unit clock
  always #5 clk = ~clk;

  pe_seq_ctrl_if #(.A_ADDR_WIDTH(AW), .B_ADDR_WIDTH(BW), .O_ADDR_WIDTH(OW)) bus ();

  pe_seq_ctrl #(.A_ADDR_WIDTH(AW), .B_ADDR_WIDTH(BW), .O_ADDR_WIDTH(OW), .PIPE_LAT(PL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          enA;
    logic [AW-1:0] addrA;
    logic          enB;
    logic [BW-1:0] addrB;
    logic          rstAcc;
    logic          accEn;
    logic          enO;
    logic          wrO;
    logic [OW-1:0] addrO;
  } outv_t;

  outv_t expv [NMAX+1];
  outv_t obs  [NMAX+1];
  bit    holdArr [NMAX+1];
  int    checks   = 0;
  int    failures = 0;
  int    doneCycle;
  int    firstDrain;

  function automatic outv_t sampleOut();
    outv_t v;
    v.busy   = bus.busy;
    v.done   = bus.done;
    v.enA    = bus.enA;
    v.addrA  = bus.addrA;
    v.enB    = bus.enB;
    v.addrB  = bus.addrB;
    v.rstAcc = bus.rst_acc;
    v.accEn  = bus.acc_en;
    v.enO    = bus.enO;
    v.wrO    = bus.wrO;
    v.addrO  = bus.addrO;
    return v;
  endfunction

  task automatic clear_hold();
    for (int c = 0; c <= NMAX; c++) holdArr[c] = 1'b0;
  endtask

  // Cycle c>=1 after the start cycle (c=0); hold during cycle c-1 gates the read shown in cycle c.
  task automatic build_model(input int k, input int t, input int rstAt);
    int cyc, a, reads;
    for (int c = 0; c <= NMAX; c++) expv[c] = '0;
    firstDrain = 0;
    if (k == 0 || t == 0) begin
      expv[1].done = 1'b1;
      doneCycle = 1;
    end else begin
      cyc = 1;
      a   = 0;
      for (int tl = 0; tl < t; tl++) begin
        expv[cyc].busy = 1'b1; expv[cyc].rstAcc = 1'b1; cyc++;
        reads = 0;
        while (reads < k && cyc < NMAX - 10) begin
          expv[cyc].busy = 1'b1;
          if (!holdArr[cyc-1]) begin
            expv[cyc].enA   = 1'b1;
            expv[cyc].addrA = AW'(a % (1 << AW));
            expv[cyc].enB   = 1'b1;
            expv[cyc].addrB = BW'(reads);
            expv[cyc+1].accEn = 1'b1;
            a++;
            reads++;
          end
          cyc++;
        end
        if (tl == 0) firstDrain = cyc;
        for (int d = 0; d < PL; d++) begin expv[cyc].busy = 1'b1; cyc++; end
        expv[cyc].busy = 1'b1; expv[cyc].enO = 1'b1; expv[cyc].wrO = 1'b1;
        expv[cyc].addrO = OW'(tl);
        cyc++;
      end
      expv[cyc].done = 1'b1;
      doneCycle = cyc;
    end
    if (rstAt > 0) for (int c = rstAt + 1; c <= NMAX; c++) expv[c] = '0;
  endtask

  // Start cycle is the current one; records outputs of cycles 1..n.
  task automatic drive_job(input int k, input int t, input int n, input int startAgain, input int rstAt);
    bus.num_k     = BW'(k);
    bus.num_tiles = OW'(t);
    bus.start     = 1'b1;
    bus.hold      = holdArr[0];
    rst           = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      obs[c]    = sampleOut();
      bus.start = (c == startAgain);
      rst       = (c == rstAt);
      bus.hold  = holdArr[c];
      if (c == 2) begin
        bus.num_k     = ~BW'(k);
        bus.num_tiles = ~OW'(t);
      end
    end
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic test_reset();
    outv_t v;
    rst = 1'b1; bus.start = 1'b1; bus.hold = 1'b0; bus.num_k = 3'd3; bus.num_tiles = 2'd1;
    repeat (2) @(posedge clk);
    #1;
    v = sampleOut();
    checks++;
    if (v !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", v); end
    rst = 1'b0; bus.start = 1'b0;
    @(posedge clk); #1;
    v = sampleOut();
    checks++;
    if (v !== '0) begin failures++; $display("FAIL idle_after_reset got=%h exp=0", v); end
  endtask

  task automatic test_basic();
    int od;
    clear_hold();
    build_model(4, 2, 0);
    drive_job(4, 2, doneCycle + 3, 0, 0);
    for (int c = 1; c <= doneCycle + 3; c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin failures++; $display("FAIL basic_trace cycle=%0d got=%h exp=%h", c, obs[c], expv[c]); end
    end
    od = -1;
    for (int c = doneCycle + 3; c >= 1; c--) if (obs[c].done === 1'b1) od = c;
    checks++;
    if (od != 17) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=17", od); end
  endtask

  task automatic test_hold();
    int od, acc;
    clear_hold();
    holdArr[3] = 1'b1; holdArr[4] = 1'b1; holdArr[5] = 1'b1;
    build_model(4, 2, 0);
    drive_job(4, 2, doneCycle + 3, 0, 0);
    od = -1; acc = 0;
    for (int c = 1; c <= doneCycle + 3; c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin failures++; $display("FAIL hold_trace cycle=%0d got=%h exp=%h", c, obs[c], expv[c]); end
      if (obs[c].accEn === 1'b1) acc++;
      if (obs[c].done === 1'b1 && od < 0) od = c;
    end
    checks++;
    if (od != 20) begin failures++; $display("FAIL hold_done_cycle got=%0d exp=20", od); end
    checks++;
    if (acc != 8) begin failures++; $display("FAIL hold_acc_en_count got=%0d exp=8", acc); end
  endtask

  task automatic test_zero_counts();
    int busyCnt;
    int cfgK [2] = '{3, 0};
    int cfgT [2] = '{0, 2};
    clear_hold();
    for (int i = 0; i < 2; i++) begin
      build_model(cfgK[i], cfgT[i], 0);
      drive_job(cfgK[i], cfgT[i], 4, 0, 0);
      busyCnt = 0;
      for (int c = 1; c <= 4; c++) begin
        checks++;
        if (obs[c] !== expv[c]) begin failures++; $display("FAIL zero_trace cfg=%0d cycle=%0d got=%h exp=%h", i, c, obs[c], expv[c]); end
        if (obs[c].busy !== 1'b0) busyCnt++;
      end
      checks++;
      if (obs[1].done !== 1'b1) begin failures++; $display("FAIL zero_done_at_1 cfg=%0d got=%b exp=1", i, obs[1].done); end
      checks++;
      if (busyCnt != 0) begin failures++; $display("FAIL zero_busy cfg=%0d got=%0d exp=0", i, busyCnt); end
    end
  endtask

  task automatic test_start_in_drain();
    int wr, dn;
    clear_hold();
    build_model(2, 3, 0);
    drive_job(2, 3, doneCycle + 4, firstDrain, 0);
    wr = 0; dn = 0;
    for (int c = 1; c <= doneCycle + 4; c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin failures++; $display("FAIL drain_start_trace cycle=%0d got=%h exp=%h", c, obs[c], expv[c]); end
      if (obs[c].wrO === 1'b1) wr++;
      if (obs[c].done === 1'b1) dn++;
    end
    checks++;
    if (wr != 3) begin failures++; $display("FAIL drain_start_writes got=%0d exp=3", wr); end
    checks++;
    if (dn != 1) begin failures++; $display("FAIL drain_start_done_pulses got=%0d exp=1", dn); end
  endtask

  task automatic test_mid_reset();
    clear_hold();
    build_model(3, 2, 10);
    drive_job(3, 2, 14, 0, 10);
    for (int c = 1; c <= 14; c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin failures++; $display("FAIL mid_reset_trace cycle=%0d got=%h exp=%h", c, obs[c], expv[c]); end
    end
    build_model(3, 2, 0);
    drive_job(3, 2, doneCycle + 3, 0, 0);
    for (int c = 1; c <= doneCycle + 3; c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin failures++; $display("FAIL after_reset_trace cycle=%0d got=%h exp=%h", c, obs[c], expv[c]); end
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] lastA;
    clear_hold();
    build_model(3, 3, 0);
    drive_job(3, 3, doneCycle + 3, 0, 0);
    lastA = '1;
    for (int c = 1; c <= doneCycle + 3; c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin failures++; $display("FAIL wrap_trace cycle=%0d got=%h exp=%h", c, obs[c], expv[c]); end
      if (obs[c].enA === 1'b1) lastA = obs[c].addrA;
    end
    checks++;
    if (lastA !== 3'd0) begin failures++; $display("FAIL wrap_last_addrA got=%0d exp=0", lastA); end
  endtask

  task automatic test_random();
    int k, t, sa;
    for (int it = 0; it < 25; it++) begin
      k = $urandom_range(0, 7);
      t = $urandom_range(0, 3);
      for (int c = 0; c <= NMAX; c++) holdArr[c] = (c < 100) && ($urandom_range(0, 3) == 0);
      build_model(k, t, 0);
      sa = ($urandom_range(0, 1) == 1) ? firstDrain : 0;
      drive_job(k, t, doneCycle + 3, sa, 0);
      for (int c = 1; c <= doneCycle + 3; c++) begin
        checks++;
        if (obs[c] !== expv[c]) begin
          failures++;
          $display("FAIL random_trace it=%0d k=%0d t=%0d cycle=%0d got=%h exp=%h", it, k, t, c, obs[c], expv[c]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.hold = 1'b0; bus.num_k = '0; bus.num_tiles = '0;
    test_reset();
    test_basic();
    test_hold();
    test_zero_counts();
    test_start_in_drain();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_seq_ctrl.md
PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

Interface
REQ-001 SHALL have parameter A_ADDR_WIDTH, default 2: A-buffer address width.
REQ-002 SHALL have parameter B_ADDR_WIDTH, default 2: B-buffer address width.
REQ-003 SHALL have parameter O_ADDR_WIDTH, default 2: O-buffer address width; also the tile-count width.
REQ-004 SHALL have parameter PIPE_LAT, default 2, legal range 1..15: PE-array cycles from the last acc_en to a valid result.
REQ-005 SHALL have port clk  input  1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-007 SHALL have ports start (input, 1: begin job, one-cycle pulse) and hold (input, 1: freeze feeding).
REQ-008 SHALL have ports num_k (input, B_ADDR_WIDTH: K-steps per tile) and num_tiles (input, O_ADDR_WIDTH: output tiles).
REQ-009 SHALL have ports enA (output, 1) and addrA (output, A_ADDR_WIDTH): A-buffer read strobe and address.
REQ-010 SHALL have ports enB (output, 1) and addrB (output, B_ADDR_WIDTH): B-buffer read strobe and address.
REQ-011 SHALL have ports rst_acc (output, 1: clear PE accumulators) and acc_en (output, 1: PE accumulate strobe).
REQ-012 SHALL have ports enO (output, 1), wrO (output, 1) and addrO (output, O_ADDR_WIDTH): O-buffer write-back.
REQ-013 SHALL have ports busy (output, 1: job in progress) and done (output, 1: one-cycle completion pulse).

Function
REQ-014 SHALL implement states IDLE, CLEAR, FEED, DRAIN, WRITE, DONE; all outputs registered.
REQ-015 In IDLE, SHALL latch num_k and num_tiles when start=1; config changes mid-job SHALL have no effect.
REQ-016 IDLE with start=1 and both counts nonzero SHALL move to CLEAR; with either count zero it SHALL move to DONE.
REQ-017 SHALL ignore start in every state other than IDLE.
REQ-018 CLEAR SHALL last exactly 1 cycle with rst_acc=1, zero the k counter, then move to FEED.
REQ-019 In FEED with hold=0: enA=enB=1, addrB=k, addrA=a_ptr; k and a_ptr SHALL then increment.
REQ-020 In FEED with hold=1: enA=enB=0, and k and a_ptr SHALL hold; the state SHALL remain FEED.
REQ-021 FEED SHALL move to DRAIN after the read with k=num_k-1 is issued; exactly num_k reads SHALL occur per tile.
REQ-022 a_ptr SHALL start at 0 per job, SHALL continue across tiles (tile t uses t*num_k..t*num_k+num_k-1), and SHALL wrap modulo 2^A_ADDR_WIDTH.
REQ-023 acc_en SHALL be a one-cycle-delayed copy of (state==FEED && hold==0), matching the 1-cycle buffer read latency.
REQ-024 DRAIN SHALL last exactly PIPE_LAT cycles via a down-counter, then move to WRITE; hold SHALL have no effect in DRAIN.
REQ-025 WRITE SHALL last 1 cycle with enO=wrO=1 and addrO=current tile index.
REQ-026 WRITE with tile=num_tiles-1 SHALL move to DONE; otherwise the tile index SHALL increment and the state SHALL move to CLEAR.
REQ-027 DONE SHALL assert done=1 for exactly 1 cycle, then move to IDLE.
REQ-028 busy SHALL be 1 in CLEAR, FEED, DRAIN and WRITE, and 0 in IDLE and DONE.
REQ-029 With hold=0, done SHALL assert N = 1 + num_tiles*(num_k+PIPE_LAT+2) cycles after the start cycle.
REQ-030 enA, enB, rst_acc, enO and wrO SHALL be 0 in every cycle not listed above.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE and zero all counters and pointers, with higher priority than start.
REQ-032 While in reset, every output SHALL be 0, including addrA, addrB and addrO.
REQ-033 A mid-job reset SHALL abandon the job without an O write or done pulse; a later start SHALL begin a fresh job from a_ptr=0.

Verification
REQ-034 PIPE_LAT=2, num_k=4, num_tiles=2, start pulse -> addrA 0..3 then 4..7; addrB 0..3 twice; two rst_acc pulses; wrO at addrO 0 then 1; done 17 cycles after start.
REQ-035 Same job with hold=1 for 3 cycles during tile 0 FEED -> no reads while held, a_ptr held; done at cycle 20; acc_en count = 8.
REQ-036 num_tiles=0, start -> done 1 cycle later; no enA, enB or wrO activity; busy stays 0.
REQ-037 start pulsed again during DRAIN -> ignored; exactly num_tiles O writes occur and exactly one done pulse.
REQ-038 rst asserted in FEED of tile 1 -> all outputs 0 next cycle and state IDLE; new start replays from addrA=0.
REQ-039 A_ADDR_WIDTH=2, num_k=3, num_tiles=2 -> addrA sequence 0,1,2,3,0,1 (wrap), with no error.
